// File: rtl/square_wave_osc_controller.sv
// Gated square-wave audio oscillator with a double-buffered period register.
// Period changes apply only at a cycle boundary, so every emitted cycle has a single consistent length.
module square_wave_osc_controller #(
  parameter int unsigned CLOCK_RATE     = 50000000,
  parameter int unsigned SAMPLE_RATE    = 48000,
  parameter int          HIGH_LEVEL     = 16384,
  parameter int unsigned DEFAULT_PERIOD = 1024,
  parameter int unsigned MIN_PERIOD     = 2
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic               gate,
  input  logic [31:0]        period_in,
  input  logic               period_load,
  output logic               period_ack,
  output logic               busy,
  output logic signed [15:0] out
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned OUT_W = 16;
  localparam logic signed [OUT_W-1:0] HIGH_Q = OUT_W'(HIGH_LEVEL);
  localparam logic [CNT_W-1:0] MIN_Q = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] DEF_Q = CNT_W'(DEFAULT_PERIOD);

  // Reject parameter sets that cannot produce a valid waveform.
  if (MIN_PERIOD < 2 || SAMPLE_RATE > CLOCK_RATE) begin : g_bad_params
    $error("square_wave_osc_controller: invalid MIN_PERIOD or rate parameters");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         active_q, active_d;
  logic [CNT_W-1:0]         pend_q, pend_d;
  logic                     pend_vld_q, pend_vld_d;
  logic                     ack_q, ack_d;
  logic                     busy_q, busy_d;
  logic signed [OUT_W-1:0]  out_q, out_d;

  logic                     wrap_c;
  logic                     xfer_c;
  logic                     phase_hi_c;
  logic [CNT_W-1:0]         cnt_inc_c;

  assign wrap_c     = (state_q != IDLE) && (cnt_q == active_q - CNT_W'(1));
  assign xfer_c     = pend_vld_q && (wrap_c || state_q == IDLE);
  assign phase_hi_c = cnt_q < (active_q >> 1);
  assign cnt_inc_c  = wrap_c ? '0 : cnt_q + CNT_W'(1);

  // Next-state: FSM, phase counter, period double-buffer and sample output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    out_d      = out_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gate) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc_c;
        // A gate drop exactly on the wrap has nothing left to drain.
        if (!gate) state_d = wrap_c ? IDLE : DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_inc_c;
        if (gate)        state_d = RUN;
        else if (wrap_c) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (xfer_c) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end

    // A load in the transfer cycle becomes the new pending value.
    if (period_load) begin
      pend_d     = (period_in < MIN_Q) ? MIN_Q : period_in;
      pend_vld_d = 1'b1;
    end

    if (audio_clk_en) begin
      out_d = (state_q != IDLE && phase_hi_c) ? HIGH_Q : '0;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      active_q   <= DEF_Q;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      out_q      <= out_d;
    end
  end

  assign period_ack = ack_q;
  assign busy       = busy_q;
  assign out        = out_q;

endmodule

// File: doc/square_wave_osc_controller.md
SQUARE_WAVE_OSC_CONTROLLER -- requirements
Module: square_wave_osc_controller

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 50000000, system clock rate in Hz (documentation and bench timing only).
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, audio sample rate in Hz (documentation only).
REQ-003 SHALL have parameter HIGH_LEVEL, default 16384, signed 16-bit output value during the high phase.
REQ-004 SHALL have parameter DEFAULT_PERIOD, default 1024, active period in clocks after reset.
REQ-005 SHALL have parameter MIN_PERIOD, default 2, lower clamp for loaded periods; MIN_PERIOD >= 2.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port I_RSTn, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port audio_clk_en, input, 1, one-clk sample strobe.
REQ-009 SHALL have port gate, input, 1, oscillator enable request, level-sensitive.
REQ-010 SHALL have port period_in, input, 32, requested period in clocks.
REQ-011 SHALL have port period_load, input, 1, one-clk pulse that captures period_in.
REQ-012 SHALL have port period_ack, output, 1, one-clk pulse when a pending period becomes active.
REQ-013 SHALL have port busy, output, 1, high when the state is not IDLE.
REQ-014 SHALL have port out, output, signed 16, registered audio sample.

Function
REQ-015 SHALL implement states IDLE, RUN and DRAIN.
REQ-016 IDLE -> RUN SHALL occur on the first clk with gate=1; the phase counter starts at 0 in that cycle.
REQ-017 RUN -> DRAIN SHALL occur on the first clk with gate=0.
REQ-018 DRAIN -> RUN SHALL occur when gate=1; the counter SHALL NOT be reset.
REQ-019 DRAIN -> IDLE SHALL occur at the counter wrap; the counter SHALL be 0 in IDLE.
REQ-020 The 32-bit counter SHALL increment each clk in RUN/DRAIN; at active_period-1 it SHALL wrap to 0 on the next clk.
REQ-021 Phase SHALL be high while counter < (active_period >> 1), otherwise low; odd periods give the shorter high half.
REQ-022 On period_load, the captured value SHALL be max(period_in, MIN_PERIOD), stored in pending, and pending_valid SHALL be set.
REQ-023 Pending SHALL transfer to active_period in the clk the counter wraps, or on the next clk while IDLE; period_ack SHALL pulse high in that same clk for exactly 1 cycle.
REQ-024 A period_load while pending_valid is set SHALL overwrite pending; only one period_ack SHALL result.
REQ-025 A period_load in the transfer clk SHALL win; the new value SHALL stay pending and the old value SHALL transfer with ack.
REQ-026 out SHALL update only in clks with audio_clk_en=1: HIGH_LEVEL if the state is not IDLE and the phase is high, else 0; otherwise out SHALL hold.
REQ-027 busy SHALL be registered and equal (state != IDLE).
REQ-028 The period SHALL never change mid-cycle; every emitted cycle SHALL be exactly one active_period long.

Reset
REQ-029 While I_RSTn=0: state=IDLE, counter=0, active_period=DEFAULT_PERIOD, pending_valid=0, period_ack=0, busy=0, out=0.
REQ-030 Reset mid-cycle SHALL discard any pending period; no ack SHALL be produced.

Verification
REQ-031 gate=1, audio_clk_en=1 every clk, DEFAULT_PERIOD=1024 -> out=16384 for 512 clks, then 0 for 512 clks; busy=1 from the clk after gate rises.
REQ-032 In RUN at counter=100, load 200 -> ack exactly at the next wrap; the following cycle is 100 high / 100 low clks.
REQ-033 Load 1 -> active period clamped to 2; out alternates 16384/0 each clk.
REQ-034 Drop gate at counter=300 -> DRAIN, cycle completes to 1023, then IDLE, busy=0, out=0 at the next strobe.
REQ-035 Two loads (500, 600) in one cycle -> single ack, active=600; load coincident with wrap -> old value active, new value acked at the following wrap.
REQ-036 Assert I_RSTn=0 with a pending load mid-cycle -> all reset values per REQ-029; after release no ack, period=1024.
